adder_rr_arbiter: RTL and testbench



---
 rtl/adder_rr_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_adder_rr_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_rr_arbiter.sv
// Round-robin sequencer that shares one fast_adder among `requesters` clients (IDLE -> EXEC -> RESP).
// Optional build macro ADDER_LOCK_EN adds a `lock` input that chains a client's next op onto the previous carry-out.

module adder_rr_blk #(
    parameter int width = 4
) (
    input  logic [width-1:0] a,
    input  logic [width-1:0] b,
    input  logic             ci,
    output logic [width-1:0] s,
    output logic             g,
    output logic             p
);
    logic [width:0] half;

    // g/p come from the carry-free sum so the block carry chain never waits on ci.
    assign half = {1'b0, a} + {1'b0, b};
    assign g    = half[width];
    assign p    = &(a ^ b);
    assign s    = half[width-1:0] + width'(ci);
endmodule

module fast_adder #(
    parameter int width        = 8,
    parameter int cascade_size = 4
) (
    input  logic [width-1:0] a,
    input  logic [width-1:0] b,
    input  logic             ci,
    output logic [width-1:0] s,
    output logic             co
);
    localparam int nblk = width / cascade_size;

    logic [nblk:0]   c;
    logic [nblk-1:0] g;
    logic [nblk-1:0] p;

    assign c[0] = ci;

    for (genvar j = 0; j < nblk; j++) begin : g_blk
        adder_rr_blk #(.width(cascade_size)) u_blk (
            .a  (a[j*cascade_size +: cascade_size]),
            .b  (b[j*cascade_size +: cascade_size]),
            .ci (c[j]),
            .s  (s[j*cascade_size +: cascade_size]),
            .g  (g[j]),
            .p  (p[j])
        );
        assign c[j+1] = g[j] | (p[j] & c[j]);
    end

    assign co = c[nblk];
endmodule

module adder_rr_arbiter #(
    parameter int requesters   = 4,
    parameter int sel_width    = 2,
    parameter int word_width   = 8,
    parameter int cascade_size = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [requesters-1:0]            req,
    input  logic [requesters*word_width-1:0] A_IN,
    input  logic [requesters*word_width-1:0] B_IN,
    input  logic [requesters-1:0]            CI_IN,
`ifdef ADDER_LOCK_EN
    input  logic [requesters-1:0]            lock,
`endif
    output logic [requesters-1:0]            gnt,
    output logic [sel_width-1:0]             gnt_id,
    output logic                             busy,
    output logic [word_width-1:0]            R_OUT,
    output logic                             C_OUT,
    output logic [requesters-1:0]            res_valid
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [requesters-1:0] one_hot0 = {{(requesters-1){1'b0}}, 1'b1};

    state_t                state;
    logic [sel_width-1:0]  ptr;
    logic [word_width-1:0] op_a;
    logic [word_width-1:0] op_b;
    logic                  op_ci;

    logic                  win_hit;
    logic [sel_width-1:0]  win_id;
    logic [sel_width-1:0]  cand;
    logic                  win_ci;

    logic [word_width-1:0] sum;
    logic                  sum_co;
    logic                  lock_take;

`ifdef ADDER_LOCK_EN
    logic lock_flag;

    // A locked owner that still requests jumps the round-robin order once.
    assign lock_take = lock_flag & req[gnt_id];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lock_flag <= 1'b0;
        end else if (state == EXEC) begin
            lock_flag <= lock[gnt_id];
        end else if (state == IDLE && lock_flag && !req[gnt_id]) begin
            lock_flag <= 1'b0;
        end
    end
`else
    assign lock_take = 1'b0;
`endif

    // Power-of-two client count lets the pointer wrap by plain truncation.
    always_comb begin
        win_hit = 1'b0;
        win_id  = '0;
        cand    = '0;
        for (int i = 1; i <= requesters; i++) begin
            cand = ptr + sel_width'(i);
            if (!win_hit && req[cand]) begin
                win_hit = 1'b1;
                win_id  = cand;
            end
        end
        if (lock_take) begin
            win_hit = 1'b1;
            win_id  = gnt_id;
        end
    end

    assign win_ci = lock_take ? C_OUT : CI_IN[win_id];

    fast_adder #(
        .width        (word_width),
        .cascade_size (cascade_size)
    ) u_add (
        .a  (op_a),
        .b  (op_b),
        .ci (op_ci),
        .s  (sum),
        .co (sum_co)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            ptr       <= sel_width'(requesters - 1);
            gnt       <= '0;
            gnt_id    <= '0;
            busy      <= 1'b0;
            R_OUT     <= '0;
            C_OUT     <= 1'b0;
            res_valid <= '0;
            op_a      <= '0;
            op_b      <= '0;
            op_ci     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_hit) begin
                        gnt    <= one_hot0 << win_id;
                        gnt_id <= win_id;
                        ptr    <= win_id;
                        op_a   <= A_IN[win_id*word_width +: word_width];
                        op_b   <= B_IN[win_id*word_width +: word_width];
                        op_ci  <= win_ci;
                        busy   <= 1'b1;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    gnt       <= '0;
                    R_OUT     <= sum;
                    C_OUT     <= sum_co;
                    res_valid <= one_hot0 << gnt_id;
                    state     <= RESP;
                end
                RESP: begin
                    res_valid <= '0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    gnt       <= '0;
                    res_valid <= '0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_adder_rr_arbiter.sv
// Scoreboard bench for adder_rr_arbiter: expected grants/results queued at drive time, popped on DUT strobes.

module tb_adder_rr_arbiter;
    localparam int N  = 4;
    localparam int SW = 2;
    localparam int W  = 8;
    localparam int CS = 4;

    logic           clk   = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   req   = '0;
    logic [N*W-1:0] A_IN  = '0;
    logic [N*W-1:0] B_IN  = '0;
    logic [N-1:0]   CI_IN = '0;
`ifdef ADDER_LOCK_EN
    logic [N-1:0]   lock  = '0;
`endif
    logic [N-1:0]   gnt;
    logic [SW-1:0]  gnt_id;
    logic           busy;
    logic [W-1:0]   R_OUT;
    logic           C_OUT;
    logic [N-1:0]   res_valid;

    typedef struct {
        int           id;
        logic [W-1:0] r;
        logic         c;
    } exp_t;

    exp_t exp_q[$];
    int   gnt_q[$];
    int   tests    = 0;
    int   fails    = 0;
    int   cyc      = 0;
    int   last_gnt = -1;
    bit   gap_chk  = 1'b0;
    int   mon_g;
    exp_t mon_e;

    adder_rr_arbiter #(
        .requesters   (N),
        .sel_width    (SW),
        .word_width   (W),
        .cascade_size (CS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .A_IN      (A_IN),
        .B_IN      (B_IN),
        .CI_IN     (CI_IN),
`ifdef ADDER_LOCK_EN
        .lock      (lock),
`endif
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .busy      (busy),
        .R_OUT     (R_OUT),
        .C_OUT     (C_OUT),
        .res_valid (res_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
        A_IN[i*W +: W] = a;
        B_IN[i*W +: W] = b;
        CI_IN[i]       = ci;
    endtask

    task automatic push(input int id, input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
        logic [W:0] full;
        exp_t       e;
        full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
        e.id = id;
        e.r  = full[W-1:0];
        e.c  = full[W];
        gnt_q.push_back(id);
        exp_q.push_back(e);
    endtask

    task automatic apply_reset();
        #1 reset = 1'b0;
        req = '0;
        gnt_q.delete();
        exp_q.delete();
        last_gnt = -1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while ((gnt_q.size() != 0 || exp_q.size() != 0) && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(tag, gnt_q.size() + exp_q.size(), 0);
    endtask

    // Wait until the grant queue shrinks to `left`, bounded by `budget` cycles.
    task automatic wait_gq(input string tag, input int left, input int budget);
        int n = 0;
        while (gnt_q.size() > left && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(tag, gnt_q.size(), left);
    endtask

    always @(negedge clk) begin
        if (gnt != '0) begin
            chk("gnt_onehot", $countones(gnt), 1);
            if (gap_chk && last_gnt >= 0) chk("gnt_gap", cyc - last_gnt, 3);
            last_gnt = cyc;
            if (gnt_q.size() == 0) begin
                chk("gnt_spurious", gnt, 0);
            end else begin
                mon_g = gnt_q.pop_front();
                chk("gnt", gnt, 32'(1) << mon_g);
                chk("gnt_id", gnt_id, mon_g);
            end
        end
        if (res_valid != '0) begin
            if (exp_q.size() == 0) begin
                chk("res_spurious", res_valid, 0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("res_valid", res_valid, 32'(1) << mon_e.id);
                chk("R_OUT", R_OUT, mon_e.r);
                chk("C_OUT", C_OUT, mon_e.c);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        apply_reset();

        // reset state and reset while idle
        chk("rst_gnt", gnt, 0);
        chk("rst_gnt_id", gnt_id, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rv", res_valid, 0);
        chk("rst_r", R_OUT, 0);
        chk("rst_c", C_OUT, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk("idle_rst_gnt", gnt, 0);
        chk("idle_rst_busy", busy, 0);
        chk("idle_rst_r", R_OUT, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // single op, exact latency
        set_op(1, 8'h3C, 8'h0F, 1'b0);
        push(1, 8'h3C, 8'h0F, 1'b0);
        req = 4'b0010;
        @(posedge clk);
        #1;
        chk("t2_gnt", gnt, 4'b0010);
        chk("t2_gnt_id", gnt_id, 1);
        chk("t2_busy", busy, 1);
        req = '0;
        @(posedge clk);
        #1;
        chk("t2_rv", res_valid, 4'b0010);
        chk("t2_r", R_OUT, 8'h4B);
        chk("t2_c", C_OUT, 0);
        chk("t2_gnt_off", gnt, 0);
        drain("t2_drain", 10);

        // carry-out boundary, single-cycle completion pulse
        set_op(3, 8'hFF, 8'h01, 1'b1);
        push(3, 8'hFF, 8'h01, 1'b1);
        req = 4'b1000;
        n = 0;
        while (res_valid == '0 && n < 10) begin
            @(posedge clk);
            #1;
            if (gnt != '0) req = '0;
            n++;
        end
        chk("t3_rv", res_valid, 4'b1000);
        chk("t3_r", R_OUT, 8'h01);
        chk("t3_c", C_OUT, 1);
        @(posedge clk);
        #1;
        chk("t3_rv_pulse", res_valid, 0);
        chk("t3_r_hold", R_OUT, 8'h01);
        chk("t3_busy_off", busy, 0);
        drain("t3_drain", 10);

        // all clients requesting: 0,1,2,3,0 at 3-cycle spacing
        apply_reset();
        for (int i = 0; i < N; i++) set_op(i, 8'($urandom), 8'($urandom), 1'($urandom));
        for (int k = 0; k < 5; k++)
            push(k % N, A_IN[(k % N)*W +: W], B_IN[(k % N)*W +: W], CI_IN[k % N]);
        gap_chk = 1'b1;
        req = 4'b1111;
        wait_gq("t4_grants", 0, 40);
        req = '0;
        drain("t4_drain", 10);

        // lone requester re-granted every 3 cycles
        last_gnt = -1;
        set_op(1, 8'h80, 8'h80, 1'b0);
        for (int k = 0; k < 3; k++) push(1, 8'h80, 8'h80, 1'b0);
        req = 4'b0010;
        wait_gq("t4b_grants", 0, 30);
        req = '0;
        drain("t4b_drain", 10);
        gap_chk = 1'b0;

        // reset during EXEC drops the op
        apply_reset();
        set_op(0, 8'h11, 8'h22, 1'b0);
        req = 4'b0001;
        n = 0;
        while (gnt == '0 && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("t5_gnt", gnt, 4'b0001);
        reset = 1'b0;
        #1;
        chk("t5_rst_gnt", gnt, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_rv", res_valid, 0);
        req = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        set_op(0, 8'h05, 8'h06, 1'b1);
        set_op(1, 8'h40, 8'h40, 1'b0);
        push(0, 8'h05, 8'h06, 1'b1);
        req = 4'b0011;
        wait_gq("t5_grant", 0, 10);
        req = '0;
        drain("t5_drain", 10);

`ifdef ADDER_LOCK_EN
        // locked multi-word add: client 2 re-granted ahead of client 3 with carry chained
        apply_reset();
        set_op(2, 8'hFF, 8'h01, 1'b0);
        set_op(3, 8'h10, 8'h20, 1'b0);
        push(2, 8'hFF, 8'h01, 1'b0);
        lock = 4'b0100;
        req  = 4'b1100;
        n = 0;
        while (res_valid == '0 && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("t6_c1", C_OUT, 1);
        lock = '0;
        set_op(2, 8'h00, 8'h00, 1'b0);
        push(2, 8'h00, 8'h00, 1'b1);
        push(3, 8'h10, 8'h20, 1'b0);
        wait_gq("t6_locked_grant", 1, 10);
        req = 4'b1000;
        wait_gq("t6_next_grant", 0, 10);
        req = '0;
        drain("t6_drain", 10);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
